pwl_mac_out: RTL and testbench
==============================

// Module: pwl_mac_out
// PURPOSE
//  Downstream stage of the piecewise-linear sigmoid segment selector.
//  - Takes x and the segment coefficients a, b read from the coefficient BRAMs.
//  - Computes y = a*x + b in a pipeline, then rounds and clamps y to unsigned [0, 1.0].
//  - Buffers results in an output FIFO with a valid/ready handshake.
//  - Throttles input by credits, since BRAM reads cannot stall.
// PARAMETERS
//  XW     32  width of x_in, signed, XFRAC fraction bits
//  XFRAC  16  fraction bits of x_in
//  CW     32  width of a_in/b_in, signed, CFRAC fraction bits
//  CFRAC  16  fraction bits of a_in/b_in
//  OW     16  width of y_out, unsigned; OW >= OFRAC+1
//  OFRAC  15  fraction bits of y_out
//  RDLAT  1   BRAM read latency in cycles (a_in/b_in valid RDLAT cycles after accept)
//  DEPTH  8   output FIFO depth, power of two; >= RDLAT+5 for full throughput
// PORTS
//  clk       in   1      clock, all logic on rising edge
//  rst       in   1      synchronous reset, active high
//  in_valid  in   1      x_in valid; segment address issued to BRAM this cycle
//  in_ready  out  1      credit available; sample accepted when in_valid&in_ready
//  x_in      in   XW     input sample
//  a_in      in   CW     slope from BRAM, valid RDLAT cycles after accept
//  b_in      in   CW     offset from BRAM, valid RDLAT cycles after accept
//  out_valid out  1      FIFO non-empty
//  out_ready in   1      consumer ready; pop when out_valid&out_ready
//  y_out     out  OW     FIFO head: sigmoid value, unsigned Q(OW-OFRAC).OFRAC
//  sat_hi    out  1      FIFO head was clamped to 1.0
//  sat_lo    out  1      FIFO head was clamped to 0
//  sat_cnt   out  16     count of clamped results, stops at 0xFFFF
// BEHAVIOUR
//  - Reset: clears pipeline valids, FIFO pointers, count and sat_cnt.
//    out_valid, y_out, sat_hi, sat_lo and sat_cnt are 0. in_ready is 0 while rst=1.
//    Samples in flight at reset are dropped; BRAM data arriving afterwards is ignored.
//  - Stage D (accept cycle t): x delayed by RDLAT; a/b sampled at t+RDLAT with the delayed x.
//  - Stage M (t+RDLAT+1): p = a*x, signed, CW+XW bits, CFRAC+XFRAC fraction bits.
//  - Stage A (t+RDLAT+2): s = p + (sext(b) << XFRAC), CW+XW+1 bits.
//  - Stage S (t+RDLAT+3): r = (s + 2^(SH-1)) >>> SH, with SH = CFRAC+XFRAC-OFRAC; round half up.
//    - r < 0: y = 0, sat_lo = 1.
//    - r > 2^OFRAC: y = 2^OFRAC, sat_hi = 1.
//    - otherwise y = r[OW-1:0].
//    - The result is written to the FIFO at the end of this cycle.
//  - Latency: out_valid rises at cycle t+RDLAT+4 (5 cycles at defaults) when the FIFO was empty.
//  - Ordering: results leave strictly in accept order; no drops, no duplicates.
//  - Credit: in_ready = !rst && (fifo_count + inflight) < DEPTH.
//    inflight = number of valid bits in stages D..S; both terms are registered.
//    A pop in the current cycle frees credit only from the next cycle.
//  - FIFO: a simultaneous push and pop keeps the count. A pop on empty is not possible, since
//    out_valid=0. A push on full cannot occur by the credit rule; assert this in simulation.
//    Pointers wrap modulo DEPTH.
//  - y_out, sat_hi and sat_lo hold their values while out_valid && !out_ready.
//  - sat_cnt increments by 1 per clamped result at FIFO write and saturates at 0xFFFF.
//  - in_valid while in_ready=0 is ignored; the upstream stage must hold the sample.
// TESTING
//  1. a=0x00004000, b=0x00008000, x=0x00010000 -> y_out=0x6000 (0.75), no sat, 5 cycles after accept.
//  2. Same a, b; x=0x00040000 -> y_out=0x8000, sat_hi=1, sat_cnt=1.
//     Then x=0xFFFC0000 -> y_out=0, sat_lo=1, sat_cnt=2.
//  3. a=0, b=0x00000001 -> y_out=0x0001 (2^-16 rounds up to 2^-15).
//     a=0, b=0 -> y_out=0.
//  4. out_ready=0, in_valid=1 for 20 cycles -> exactly 8 accepted, in_ready stays 0.
//     Then out_ready=1 -> 8 results in order, then intake resumes, nothing lost.
//  5. Random in_valid/out_ready, 10k samples against a reference model
//     -> bit-exact, in-order, 1 result/cycle when out_ready is held high.
//  6. rst pulsed with 3 samples in flight and 4 in the FIFO
//     -> next cycle out_valid=0, sat_cnt=0, no stale result ever emitted.

Source files
------------

// File: rtl/pwl_mac_out.sv
// Output stage of the piecewise-linear sigmoid: y = a*x + b, round, clamp to [0, 1.0],
// then buffer in a FIFO whose free space is handed upstream as credits.
module pwl_mac_out #(
   parameter int XW    = 32,
   parameter int XFRAC = 16,
   parameter int CW    = 32,
   parameter int CFRAC = 16,
   parameter int OW    = 16,
   parameter int OFRAC = 15,
   parameter int RDLAT = 1,
   parameter int DEPTH = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [XW-1:0] x_in,
   input  logic [CW-1:0] a_in,
   input  logic [CW-1:0] b_in,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [OW-1:0] y_out,
   output logic          sat_hi,
   output logic          sat_lo,
   output logic [15:0]   sat_cnt
);

   localparam int PW = CW + XW;
   localparam int SW = PW + 1;
   localparam int SH = CFRAC + XFRAC - OFRAC;
   localparam int RW = SW - SH;
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int NW = AW + 1;
   localparam int EW = OW + 2;
   localparam logic [RW-1:0] R_ONE   = RW'(1) << OFRAC;
   localparam logic [OW-1:0] Y_ONE   = OW'(1) << OFRAC;
   localparam logic [SW-1:0] RND     = SW'(1) << (SH - 1);
   localparam logic [NW:0]   DEPTH_N = (NW + 1)'(DEPTH);

   logic                 accept, push, pop;
   logic [NW-1:0]        count_q, count_d, inflight_q, inflight_d;
   logic [AW-1:0]        wr_ptr_q, rd_ptr_q;
   logic [EW-1:0]        mem_q [DEPTH];
   logic [EW-1:0]        head;
   logic [15:0]          sat_cnt_q;

   logic                 dly_v;
   logic [XW-1:0]        dly_x;
   logic                 d_v_q, m_v_q, a_v_q;
   logic signed [CW-1:0] d_a_q, d_b_q, m_b_q;
   logic signed [XW-1:0] d_x_q;
   logic signed [PW-1:0] a_ext, x_ext, m_p_d, m_p_q;
   logic signed [SW-1:0] p_ext, b_ext, a_s_d, a_s_q, s_rnd;
   logic [RW-1:0]        s_r;
   logic                 s_lo, s_hi;
   logic [OW-1:0]        s_y;

   // Credits: everything already in the FIFO or still in the pipe has a reserved slot.
   assign in_ready = !rst && (({1'b0, count_q} + {1'b0, inflight_q}) < DEPTH_N);
   assign accept   = in_valid && in_ready;
   assign push     = a_v_q;
   assign pop      = out_valid && out_ready;

   // x waits here for the coefficient read to come back from the BRAM.
   genvar gi;
   generate
      for (gi = 0; gi < RDLAT; gi++) begin : g_dly
         logic          v_q;
         logic [XW-1:0] x_q;
         if (gi == 0) begin : g_head
            always_ff @(posedge clk) begin
               if (rst) v_q <= 1'b0;
               else     v_q <= accept;
               x_q <= x_in;
            end
         end else begin : g_tail
            always_ff @(posedge clk) begin
               if (rst) v_q <= 1'b0;
               else     v_q <= g_dly[gi-1].v_q;
               x_q <= g_dly[gi-1].x_q;
            end
         end
      end
   endgenerate

   assign dly_v = g_dly[RDLAT-1].v_q;
   assign dly_x = g_dly[RDLAT-1].x_q;

   assign a_ext = PW'(d_a_q);
   assign x_ext = PW'(d_x_q);
   assign m_p_d = a_ext * x_ext;
   assign p_ext = SW'(m_p_q);
   assign b_ext = SW'(m_b_q);
   assign a_s_d = p_ext + (b_ext <<< XFRAC);

   always_ff @(posedge clk) begin
      if (rst) begin
         d_v_q <= 1'b0;
         m_v_q <= 1'b0;
         a_v_q <= 1'b0;
      end else begin
         d_v_q <= dly_v;
         m_v_q <= d_v_q;
         a_v_q <= m_v_q;
      end
      d_a_q <= a_in;
      d_b_q <= b_in;
      d_x_q <= dly_x;
      m_p_q <= m_p_d;
      m_b_q <= d_b_q;
      a_s_q <= a_s_d;
   end

   // Round half up, then clamp to the unsigned output range [0, 1.0].
   assign s_rnd = a_s_q + RND;
   assign s_r   = RW'(s_rnd >>> SH);
   assign s_lo  = s_r[RW-1];
   assign s_hi  = !s_r[RW-1] && (s_r > R_ONE);
   assign s_y   = s_lo ? '0 : (s_hi ? Y_ONE : s_r[OW-1:0]);

   always_comb begin
      count_d    = count_q + NW'(push) - NW'(pop);
      inflight_d = inflight_q + NW'(accept) - NW'(push);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count_q    <= '0;
         inflight_q <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         sat_cnt_q  <= '0;
      end else begin
         count_q    <= count_d;
         inflight_q <= inflight_d;
         if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
         if (push && (s_hi || s_lo) && (sat_cnt_q != 16'hFFFF))
            sat_cnt_q <= sat_cnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= {s_hi, s_lo, s_y};
   end

   assign head      = mem_q[rd_ptr_q];
   assign out_valid = (count_q != '0);
   assign y_out     = out_valid ? head[OW-1:0] : '0;
   assign sat_hi    = out_valid && head[EW-1];
   assign sat_lo    = out_valid && head[EW-2];
   assign sat_cnt   = sat_cnt_q;

   a_no_push_full: assert property (@(posedge clk) disable iff (rst)
                                    !(push && (count_q == NW'(DEPTH))));

endmodule

// File: tb/tb_pwl_mac_out.sv
// Directed and randomised checks of pwl_mac_out with a one-cycle BRAM model and a
// scoreboard queue of expected results in accept order.
module tb_pwl_mac_out;

   logic        clk, rst, in_valid, in_ready, out_valid, out_ready;
   logic [31:0] x_in, a_in, b_in;
   logic [15:0] y_out, sat_cnt;
   logic        sat_hi, sat_lo;

   pwl_mac_out dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .x_in(x_in), .a_in(a_in), .b_in(b_in),
      .out_valid(out_valid), .out_ready(out_ready), .y_out(y_out),
      .sat_hi(sat_hi), .sat_lo(sat_lo), .sat_cnt(sat_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] a, b, x;
      logic [15:0] y;
      logic        hi, lo;
   } smp_t;

   smp_t sq[$];
   smp_t eq[$];
   smp_t pend;
   bit   pend_v;
   int   n_total, n_bad;
   int   vpct, rpct, cyc, acc_cyc, acc_cnt, npop, exp_sat;
   bit   verbose;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic smp_t model(input logic [31:0] a, input logic [31:0] b, input logic [31:0] x);
      smp_t   s;
      longint p, sm, r;
      p  = longint'($signed(a)) * longint'($signed(x));
      sm = p + (longint'($signed(b)) <<< 16);
      r  = (sm + 64'sd65536) >>> 17;
      s.a = a; s.b = b; s.x = x;
      s.hi = 1'b0; s.lo = 1'b0;
      if (r < 0) begin
         s.y = 16'h0000; s.lo = 1'b1;
      end else if (r > 32768) begin
         s.y = 16'h8000; s.hi = 1'b1;
      end else begin
         s.y = r[15:0];
      end
      return s;
   endfunction

   task automatic add(input logic [31:0] a, input logic [31:0] b, input logic [31:0] x,
                      input logic [15:0] y, input logic hi, input logic lo);
      smp_t s;
      s.a = a; s.b = b; s.x = x; s.y = y; s.hi = hi; s.lo = lo;
      sq.push_back(s);
   endtask

   task automatic add_rand();
      logic [31:0] a, b, x;
      if ($urandom_range(3) == 0) begin
         a = $urandom; b = $urandom; x = $urandom;
      end else begin
         a = $urandom_range(0, 32'h8000);
         b = $urandom_range(0, 32'h10000);
         x = $urandom_range(0, 32'h100000) - 32'h80000;
      end
      sq.push_back(model(a, b, x));
   endtask

   // One clock cycle: BRAM answers last cycle's accept, new inputs are driven, outputs checked.
   task automatic tick();
      smp_t s;
      bit   acc, pop;
      if (pend_v) begin
         a_in = pend.a; b_in = pend.b;
      end else begin
         a_in = $urandom; b_in = $urandom;
      end
      in_valid  = (sq.size() > 0) && ($urandom_range(99) < vpct);
      x_in      = (sq.size() > 0) ? sq[0].x : $urandom;
      out_ready = ($urandom_range(99) < rpct);
      #1;
      acc = in_valid && in_ready;
      pop = out_valid && out_ready;
      if (pop) begin
         npop++;
         check("pop_expected", (eq.size() > 0), 1'b1);
         if (eq.size() > 0) begin
            s = eq.pop_front();
            check("y_out", y_out, s.y);
            check("sat_hi", sat_hi, s.hi);
            check("sat_lo", sat_lo, s.lo);
            if (verbose)
               $display("pop y=%h hi=%0d lo=%0d (exp y=%h)", y_out, sat_hi, sat_lo, s.y);
         end
      end
      if (acc) begin
         s = sq.pop_front();
         eq.push_back(s);
         acc_cnt++;
         acc_cyc = cyc;
         if (s.hi || s.lo) exp_sat++;
         pend = s;
      end
      pend_v = acc;
      cyc++;
      @(negedge clk);
   endtask

   task automatic drain(input int maxc);
      int n;
      vpct = 100; rpct = 100; n = 0;
      while ((sq.size() > 0 || eq.size() > 0) && n < maxc) begin
         tick();
         n++;
      end
      check("drain_done", sq.size() + eq.size(), 0);
   endtask

   initial begin
      int n, a0, p0;
      n_total = 0; n_bad = 0; cyc = 0; acc_cyc = 0; acc_cnt = 0; npop = 0; exp_sat = 0;
      pend_v = 0; verbose = 1;
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; x_in = '0; a_in = '0; b_in = '0;
      repeat (3) @(negedge clk);
      #1;
      check("rst_in_ready", in_ready, 1'b0);
      check("rst_out_valid", out_valid, 1'b0);
      check("rst_y_out", y_out, 16'h0);
      check("rst_sat_hi", sat_hi, 1'b0);
      check("rst_sat_lo", sat_lo, 1'b0);
      check("rst_sat_cnt", sat_cnt, 16'h0);
      rst = 1'b0;
      #1;
      check("ready_after_rst", in_ready, 1'b1);
      @(negedge clk);

      // 1: 0.25*1.0 + 0.5 = 0.75, first result five cycles after accept
      add(32'h4000, 32'h8000, 32'h10000, 16'h6000, 1'b0, 1'b0);
      vpct = 100; rpct = 0; a0 = acc_cnt; n = 0;
      while (acc_cnt == a0 && n < 10) begin tick(); n++; end
      while (!out_valid && (cyc - acc_cyc) < 20) tick();
      check("t1_latency", cyc - acc_cyc, 5);
      drain(50);

      // 2: clamp high then low
      add(32'h4000, 32'h8000, 32'h40000, 16'h8000, 1'b1, 1'b0);
      add(32'h4000, 32'h8000, 32'hFFFC0000, 16'h0000, 1'b0, 1'b1);
      drain(50);
      check("t2_sat_cnt", sat_cnt, 16'd2);

      // 3: rounding of the smallest offset, and zero
      add(32'h0, 32'h1, 32'h12345, 16'h0001, 1'b0, 1'b0);
      add(32'h0, 32'h0, 32'h12345, 16'h0000, 1'b0, 1'b0);
      drain(50);
      check("t3_sat_cnt", sat_cnt, 16'd2);

      // 4: consumer stalled -> exactly DEPTH accepts, then everything comes out in order
      for (int i = 0; i < 20; i++)
         add(32'h0, 32'(i * 256), 32'(i * 32'h1234), 16'(i * 128), 1'b0, 1'b0);
      vpct = 100; rpct = 0; a0 = acc_cnt;
      repeat (20) tick();
      check("t4_accepted", acc_cnt - a0, 8);
      check("t4_in_ready", in_ready, 1'b0);
      drain(200);

      // 5: random traffic against the model, then full-rate streaming
      verbose = 0;
      for (int i = 0; i < 10000; i++) add_rand();
      vpct = 70; rpct = 60; n = 0;
      while (sq.size() > 0 && n < 60000) begin tick(); n++; end
      drain(500);
      check("t5_sat_cnt", sat_cnt, 16'(exp_sat));
      for (int i = 0; i < 200; i++) add_rand();
      vpct = 100; rpct = 100;
      repeat (20) tick();
      p0 = npop;
      repeat (100) tick();
      check("t5_throughput", npop - p0, 100);
      drain(500);
      verbose = 1;

      // 6: reset with results both in flight and queued; none may survive
      for (int i = 0; i < 7; i++) add(32'h4000, 32'h8000, 32'h40000, 16'h8000, 1'b1, 1'b0);
      vpct = 100; rpct = 0; n = 0;
      while (sq.size() > 0 && n < 30) begin tick(); n++; end
      tick();
      check("t6_fifo_nonempty", out_valid, 1'b1);
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      #1;
      check("t6_rst_in_ready", in_ready, 1'b0);
      @(negedge clk);
      check("t6_out_valid", out_valid, 1'b0);
      check("t6_sat_cnt", sat_cnt, 16'h0);
      check("t6_y_out", y_out, 16'h0);
      rst = 1'b0;
      sq.delete(); eq.delete(); pend_v = 0; exp_sat = 0;
      vpct = 100; rpct = 100;
      repeat (15) tick();
      check("t6_no_stale", npop - p0 > 0 ? eq.size() : 0, 0);
      add(32'h4000, 32'h8000, 32'h10000, 16'h6000, 1'b0, 1'b0);
      drain(50);
      check("t6_sat_cnt_after", sat_cnt, 16'h0);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
